spi_master_frame: RTL and testbench

- Host-side SPI master, the opposite end of the slave byte buffer on the SPI link.
- Sends a frame of FRAME_BYTES bytes from an internal TX buffer in one chip-select window.
- Captures the same number of bytes from MISO into an RX buffer.
- Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first. Used by the test harness and by host-side bridges to drive the NITTA SPI slave.

---
 rtl/spi_master_frame.sv | 165 ++++++++++++++++
 tb/tb_spi_master_frame.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_frame.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first master: shifts one frame of FRAME_BYTES words from a TX buffer
// into an RX buffer inside a single cs_n window. Define SPI_MASTER_LOOPBACK_EN to sample mosi instead of miso.
module spi_master_frame #(
    parameter int  SPI_DATA_WIDTH = 8,
    parameter int  FRAME_BYTES    = 6,
    parameter int  CLK_DIV        = 4,
    localparam int ADDR_WIDTH     = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic                      tx_wr,
    input  logic [ADDR_WIDTH-1:0]     tx_addr,
    input  logic [SPI_DATA_WIDTH-1:0] tx_data,
    input  logic [ADDR_WIDTH-1:0]     rx_addr,
    output logic [SPI_DATA_WIDTH-1:0] rx_data,
    output logic                      sclk,
    output logic                      cs_n,
    output logic                      mosi,
    input  logic                      miso
);
    localparam int W     = SPI_DATA_WIDTH;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0]      DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(W - 1);
    localparam logic [ADDR_WIDTH-1:0] BYTE_LAST = ADDR_WIDTH'(FRAME_BYTES - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(FRAME_BYTES);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD} state_t;

    state_t                state;
    logic [CNT_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [ADDR_WIDTH-1:0] byte_idx;
    logic                  last_word;
    logic [W-1:0]          tx_shift;
    logic [W-1:0]          rx_shift;

    logic [W-1:0] tx_mem [FRAME_BYTES];
    logic [W-1:0] rx_mem [FRAME_BYTES];

    logic                  div_end;
    logic [CNT_W-1:0]      div_next;
    logic [ADDR_WIDTH-1:0] byte_next;
    logic [W-1:0]          tx_next;
    logic [W-1:0]          rx_next;
    logic                  sample_bit;
    logic                  tx_we;
    logic                  rx_we;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign sample_bit  = mosi;
`else
    assign sample_bit  = miso;
`endif

    assign div_end   = (div_cnt == DIV_LAST);
    assign div_next  = div_end ? '0 : div_cnt + 1'b1;
    assign byte_next = byte_idx + 1'b1;
    assign tx_next   = tx_shift << 1;
    assign rx_next   = (rx_shift << 1) | W'(sample_bit);

    // TX is frozen once a frame is running; RX word i lands on the falling edge that ends its last bit.
    assign tx_we = tx_wr && (state == IDLE) && ({1'b0, tx_addr} < DEPTH);
    assign rx_we = (state == SHIFT_HI) && div_end && (bit_idx == '0);

    // NOTE: the buffers have no reset so they map onto plain RAM; only control state is cleared by rst.
    always_ff @(posedge clk) begin
        if (tx_we) tx_mem[tx_addr]  <= tx_data;
        if (rx_we) rx_mem[byte_idx] <= rx_shift;
    end

    assign rx_data = ({1'b0, rx_addr} < DEPTH) ? rx_mem[rx_addr] : '0;

    // NOTE: all state and outputs update with <= so every register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            last_word <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SETUP;
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                        tx_shift  <= tx_mem[0];
                        mosi      <= tx_mem[0][W-1];
                        div_cnt   <= '0;
                        bit_idx   <= BIT_LAST;
                        byte_idx  <= '0;
                        last_word <= 1'b0;
                    end
                end
                SETUP: begin
                    div_cnt <= div_next;
                    if (div_end) begin
                        sclk     <= 1'b1;
                        rx_shift <= rx_next;
                        state    <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    div_cnt <= div_next;
                    if (div_end) begin
                        sclk  <= 1'b0;
                        state <= SHIFT_LO;
                        if (bit_idx != '0) begin
                            bit_idx  <= bit_idx - 1'b1;
                            tx_shift <= tx_next;
                            mosi     <= tx_next[W-1];
                        end else if (byte_idx != BYTE_LAST) begin
                            // Next word follows with no gap: its MSB goes out on this falling edge.
                            byte_idx <= byte_next;
                            bit_idx  <= BIT_LAST;
                            tx_shift <= tx_mem[byte_next];
                            mosi     <= tx_mem[byte_next][W-1];
                        end else begin
                            last_word <= 1'b1;
                        end
                    end
                end
                SHIFT_LO: begin
                    div_cnt <= div_next;
                    if (div_end) begin
                        if (last_word) begin
                            state <= HOLD;
                        end else begin
                            sclk     <= 1'b1;
                            rx_shift <= rx_next;
                            state    <= SHIFT_HI;
                        end
                    end
                end
                HOLD: begin
                    div_cnt <= div_next;
                    if (div_end) begin
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        mosi  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_frame.sv
// Bench for spi_master_frame: two instances (CLK_DIV=2 and CLK_DIV=1, 3-byte frames) driven by a mode-0
// slave model that glitches miso while sclk is high; results compared against a frame-level reference.
module tb_spi_master_frame;
    localparam int NB    = 3;
    localparam int NBITS = 8 * NB;
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, tx_wr;
    logic [1:0] tx_addr, rx_addr;
    logic [7:0] tx_data;
    logic [1:0] busy, done, sclk, cs_n, mosi;
    logic [7:0] rx_data [2];

    logic [NBITS-1:0] slave_word [2];
    logic [NBITS-1:0] cap [2];
    int               nbits [2];
    int               viol [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic int div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int DIV = (d == 0) ? 2 : 1;
        logic miso;
        logic p_sclk = 1'b0;
        logic p_mosi = 1'b0;

        spi_master_frame #(.SPI_DATA_WIDTH(8), .FRAME_BYTES(NB), .CLK_DIV(DIV)) dut (
            .clk(clk), .rst(rst), .start(start[d]), .busy(busy[d]), .done(done[d]),
            .tx_wr(tx_wr[d]), .tx_addr(tx_addr), .tx_data(tx_data),
            .rx_addr(rx_addr), .rx_data(rx_data[d]),
            .sclk(sclk[d]), .cs_n(cs_n[d]), .mosi(mosi[d]), .miso(miso)
        );

        // Mode-0 slave: data valid from each falling edge, inverted junk while sclk is high.
        initial begin
            miso     = 1'b0;
            cap[d]   = '0;
            nbits[d] = 0;
            forever begin
                @(negedge cs_n[d]);
                cap[d]   = '0;
                nbits[d] = 0;
                for (int k = 0; k < NBITS; k++) begin
                    miso = slave_word[d][NBITS-1-k];
                    @(posedge sclk[d] or posedge cs_n[d]);
                    if (cs_n[d]) break;
                    cap[d]   = {cap[d][NBITS-2:0], mosi[d]};
                    nbits[d] = nbits[d] + 1;
                    #1 miso = ~miso;
                    @(negedge sclk[d] or posedge cs_n[d]);
                    if (cs_n[d]) break;
                end
                miso = 1'b0;
            end
        end

        initial viol[d] = 0;
        always @(negedge clk) begin
            if (sclk[d] && cs_n[d]) viol[d] = viol[d] + 1;
            if (sclk[d] && !p_sclk && (mosi[d] !== p_mosi)) viol[d] = viol[d] + 1;
            p_sclk = sclk[d];
            p_mosi = mosi[d];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_tx(input int d, input logic [NBITS-1:0] w);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            tx_wr[d] = 1'b1;
            tx_addr  = 2'(i);
            tx_data  = w[NBITS-1-8*i -: 8];
        end
        @(negedge clk);
        tx_wr[d] = 1'b0;
    endtask

    // Runs one frame on instance d and checks length, done, MOSI stream and RX contents.
    // chained: start is raised now (caller is on the done cycle). keep: return on the done cycle.
    task automatic frame(input int d, input logic [NBITS-1:0] tx_exp, input logic [NBITS-1:0] sl,
                         input bit poke, input bit chained, input bit keep);
        int               low;
        int               dcnt;
        logic [NBITS-1:0] rx_exp;
        slave_word[d] = sl;
        if (chained) begin
            start[d] = 1'b1;
            @(negedge clk);
            start[d] = 1'b0;
            check($sformatf("d%0d_b2b_cs_gap", d), cs_n[d], 1'b0);
        end else begin
            @(negedge clk);
            start[d] = 1'b1;
            @(negedge clk);
            start[d] = 1'b0;
        end
        check($sformatf("d%0d_busy_on", d), busy[d], 1'b1);
        low  = 0;
        dcnt = 0;
        while (cs_n[d] === 1'b0 && low < 400) begin
            if (poke && low == 20) begin
                start[d] = 1'b1;
                tx_wr[d] = 1'b1;
                tx_addr  = 2'd0;
                tx_data  = 8'h00;
            end
            @(negedge clk);
            start[d] = 1'b0;
            tx_wr[d] = 1'b0;
            low++;
            if (done[d]) dcnt++;
        end
        check($sformatf("d%0d_cs_low_len", d), low, div_of(d) * (2 + 2 * NBITS));
        check($sformatf("d%0d_done_at_cs_rise", d), done[d], 1'b1);
        check($sformatf("d%0d_busy_off", d), busy[d], 1'b0);
        check($sformatf("d%0d_mosi_stream", d), cap[d], tx_exp);
        check($sformatf("d%0d_bit_count", d), nbits[d], NBITS);
        rx_exp = LOOPBACK ? tx_exp : sl;
        for (int i = 0; i < NB; i++) begin
            rx_addr = 2'(i);
            #1;
            check($sformatf("d%0d_rx%0d", d, i), rx_data[d], rx_exp[NBITS-1-8*i -: 8]);
        end
        if (!keep) begin
            repeat (3) begin
                @(negedge clk);
                if (done[d]) dcnt++;
            end
            check($sformatf("d%0d_done_once", d), dcnt, 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               found;
        int               quiet;
        logic [NBITS-1:0] t;
        logic [NBITS-1:0] s;
        rst     = 1'b1;
        start   = '0;
        tx_wr   = '0;
        tx_addr = '0;
        tx_data = '0;
        rx_addr = '0;
        slave_word[0] = '0;
        slave_word[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 2'b00);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_busy", busy, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_mosi", mosi, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Directed frame; the out-of-range write must not disturb the buffer.
        load_tx(0, 24'hA53CFF);
        @(negedge clk);
        tx_wr[0] = 1'b1;
        tx_addr  = 2'd3;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_wr[0] = 1'b0;
        frame(0, 24'hA53CFF, 24'h123456, 1'b0, 1'b0, 1'b0);

        load_tx(1, 24'hA53CFF);
        frame(1, 24'hA53CFF, 24'h123456, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 2; d++) begin
                t = NBITS'($urandom);
                s = NBITS'($urandom);
                load_tx(d, t);
                frame(d, t, s, 1'b0, 1'b0, 1'b0);
            end
        end

        // Asynchronous reset while sclk is high aborts the frame immediately.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (sclk[0]) found = 1;
        end
        check("rst_mid_reach_hi", found, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_sclk", sclk[0], 1'b0);
        check("rst_mid_cs_n", cs_n[0], 1'b1);
        check("rst_mid_busy", busy[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        repeat (60) begin
            @(negedge clk);
            if (done[0] || !cs_n[0] || busy[0]) quiet++;
        end
        check("rst_mid_no_done", quiet, 0);

        // Lockout: start and a TX write mid-frame are ignored; then a back-to-back frame.
        t = NBITS'($urandom) | 24'h010000;
        load_tx(0, t);
        frame(0, t, NBITS'($urandom), 1'b1, 1'b0, 1'b1);
        frame(0, t, NBITS'($urandom), 1'b0, 1'b1, 1'b0);

        t = NBITS'($urandom);
        load_tx(1, t);
        frame(1, t, NBITS'($urandom), 1'b1, 1'b0, 1'b1);
        frame(1, t, NBITS'($urandom), 1'b0, 1'b1, 1'b0);

        // Loopback pattern with a silent slave.
        load_tx(0, 24'h01807E);
        frame(0, 24'h01807E, 24'h000000, 1'b0, 1'b0, 1'b0);

        check("d0_sclk_mosi_rules", viol[0], 0);
        check("d1_sclk_mosi_rules", viol[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
